// File: rtl/bus_coherence_ctrl.sv
// Snooping bus controller: round-robin arbitration of two dcaches onto one RAM port.
// Define BUS_CTRL_C2C_EN to forward dirty snoop data cache-to-cache; otherwise it goes through RAM.
module bus_coherence_ctrl #(
    parameter int CPUS   = 2,
    parameter int WORD_W = 32
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic [CPUS-1:0]              dREN,
    input  logic [CPUS-1:0]              dWEN,
    input  logic [CPUS-1:0][31:0]        daddr,
    input  logic [CPUS-1:0][WORD_W-1:0]  dstore,
    input  logic [CPUS-1:0]              cctrans,
    input  logic [CPUS-1:0]              ccwrite,
    input  logic [CPUS-1:0]              snpvalid,
    input  logic [CPUS-1:0]              snpdirty,
    output logic [CPUS-1:0]              dwait,
    output logic [CPUS-1:0][WORD_W-1:0]  dload,
    output logic [CPUS-1:0]              ccwait,
    output logic [CPUS-1:0]              ccinv,
    output logic [CPUS-1:0][31:0]        ccsnoopaddr,
    output logic                         ramREN,
    output logic                         ramWEN,
    output logic [31:0]                  ramaddr,
    output logic [WORD_W-1:0]            ramstore,
    input  logic [WORD_W-1:0]            ramload,
    input  logic [1:0]                   ramstate
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [3:0] {
        IDLE, ARB, SNOOP,
`ifdef BUS_CTRL_C2C_EN
        C2C0, C2C1,
`endif
        LOAD0, LOAD1, WB0, WB1, UPG
    } state_t;

    state_t          state;
    logic            last;
    logic            req;
    logic            peer;
    logic            peer_wb;
    logic            wb_src;
    logic            gnt;
    logic            gnt_peer;
    logic            access;
    logic [CPUS-1:0] pend;

    assign peer     = ~req;
    assign access   = (ramstate == RAM_ACCESS);
    assign pend     = (dREN | dWEN | cctrans) & ~ccwait;
    assign gnt      = (pend == 2'b11) ? ~last : pend[1];
    assign gnt_peer = ~gnt;
    // Without cache-to-cache forwarding, the peer's dirty block is written back before the fill.
    assign wb_src   = peer_wb ? peer : req;

`ifdef BUS_CTRL_C2C_EN
    assign peer_wb = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            last        <= 1'b1;
            req         <= 1'b0;
            ccwait      <= '0;
            ccinv       <= '0;
            ccsnoopaddr <= '0;
`ifndef BUS_CTRL_C2C_EN
            peer_wb     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|pend) state <= ARB;
                end
                ARB: begin
                    if (|pend) begin
                        req <= gnt;
                        if (cctrans[gnt]) begin
                            state                 <= SNOOP;
                            ccwait[gnt_peer]      <= 1'b1;
                            ccinv[gnt_peer]       <= ccwrite[gnt];
                            ccsnoopaddr[gnt_peer] <= {daddr[gnt][31:3], 3'b000};
                        end else if (dWEN[gnt]) begin
                            state <= WB0;
                        end else begin
                            state <= LOAD0;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                SNOOP: begin
                    if (snpvalid[peer]) begin
                        if (!dREN[req]) begin
                            state       <= UPG;
                            ccwait      <= '0;
                            ccinv       <= '0;
                            ccsnoopaddr <= '0;
                        end else if (snpdirty[peer]) begin
`ifdef BUS_CTRL_C2C_EN
                            state <= C2C0;
`else
                            state   <= WB0;
                            peer_wb <= 1'b1;
`endif
                        end else begin
                            state       <= LOAD0;
                            ccwait      <= '0;
                            ccinv       <= '0;
                            ccsnoopaddr <= '0;
                        end
                    end
                end
`ifdef BUS_CTRL_C2C_EN
                C2C0: begin
                    if (access) state <= C2C1;
                end
                C2C1: begin
                    if (access) begin
                        state       <= IDLE;
                        last        <= req;
                        ccwait      <= '0;
                        ccinv       <= '0;
                        ccsnoopaddr <= '0;
                    end
                end
`endif
                LOAD0: begin
                    if (access) state <= LOAD1;
                end
                LOAD1: begin
                    if (access) begin
                        state <= IDLE;
                        last  <= req;
                    end
                end
                WB0: begin
                    if (access) state <= WB1;
                end
                WB1: begin
                    if (access) begin
`ifndef BUS_CTRL_C2C_EN
                        if (peer_wb) begin
                            state       <= LOAD0;
                            peer_wb     <= 1'b0;
                            ccwait      <= '0;
                            ccinv       <= '0;
                            ccsnoopaddr <= '0;
                        end else begin
                            state <= IDLE;
                            last  <= req;
                        end
`else
                        state <= IDLE;
                        last  <= req;
`endif
                    end
                end
                UPG: begin
                    state <= IDLE;
                    last  <= req;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ERROR and BUSY both simply hold the word until ACCESS arrives.
    always_comb begin
        dwait    = '1;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
`ifdef BUS_CTRL_C2C_EN
            C2C0, C2C1: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[peer];
                ramstore = dstore[peer];
                if (access) begin
                    dload[req]  = dstore[peer];
                    dwait[req]  = 1'b0;
                    dwait[peer] = 1'b0;
                end
            end
`endif
            LOAD0, LOAD1: begin
                ramREN  = 1'b1;
                ramaddr = daddr[req];
                if (access) begin
                    dload[req] = ramload;
                    dwait[req] = 1'b0;
                end
            end
            WB0, WB1: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[wb_src];
                ramstore = dstore[wb_src];
                if (access) dwait[wb_src] = 1'b0;
            end
            UPG: dwait[req] = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_coherence_ctrl.sv
// Bench for bus_coherence_ctrl: cache/peer/RAM models driven from one process, scoreboarded acks.
module tb_bus_coherence_ctrl;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERR = 2'd3;

    typedef enum logic [1:0] {J_READ, J_WRITE, J_UPG} kind_t;
    typedef struct { int cache; logic chk; logic [31:0] data; } exp_t;
    typedef struct { int cache; kind_t kind; logic [31:0] addr; logic [31:0] d0; logic [31:0] d1; bit preload; } vec_t;

    logic CLK = 1'b0;
    logic nRST;
    logic [1:0] dREN, dWEN, cctrans, ccwrite, snpvalid, snpdirty;
    logic [1:0][31:0] daddr, dstore, dload, ccsnoopaddr;
    logic [1:0] dwait, ccwait, ccinv;
    logic ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    logic [1:0] ramstate;

    logic [31:0] mem [0:1023];
    logic use_ovr;
    logic [1:0] ovr;

    assign ramload  = mem[ramaddr[11:2]];
    assign ramstate = use_ovr ? ovr : ((ramREN | ramWEN) ? ACCESS : FREE);

    always #5 CLK = ~CLK;

    bus_coherence_ctrl #(.CPUS(2), .WORD_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .cctrans(cctrans), .ccwrite(ccwrite), .snpvalid(snpvalid), .snpdirty(snpdirty),
        .dwait(dwait), .dload(dload), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    int tests, fails;
    exp_t expq[$];
    int order[$];
    logic [63:0] wlog[$];
    bit ram_seen;

    bit job_act[2];
    kind_t job_kind[2];
    logic job_cc[2], job_ccw[2];
    logic [31:0] job_addr[2], job_d0[2], job_d1[2];
    int job_acks[2], job_len[2];

    bit snp_done[2], sup[2];
    int snp_cnt[2], sup_cnt[2];
    int snp_delay;
    bit peer_dirty;
    logic [31:0] peer_d0, peer_d1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic int ord_code();
        int v = 0;
        foreach (order[i]) v = v * 16 + order[i];
        return (order.size() << 12) | v;
    endfunction

    // Requester and snooped-peer behaviour, applied just after each rising edge.
    task automatic drive();
        for (int k = 0; k < 2; k++) begin
            dREN[k] = 0; dWEN[k] = 0; cctrans[k] = 0; ccwrite[k] = 0;
            daddr[k] = '0; dstore[k] = '0; snpvalid[k] = 0; snpdirty[k] = 0;
            if (!ccwait[k]) begin
                snp_done[k] = 0; snp_cnt[k] = 0; sup[k] = 0;
            end else if (!snp_done[k]) begin
                if (snp_cnt[k] >= snp_delay) begin
                    snpvalid[k] = 1; snpdirty[k] = peer_dirty; snp_done[k] = 1;
                    sup[k] = peer_dirty; sup_cnt[k] = 0;
                end else snp_cnt[k]++;
            end
            if (sup[k] && sup_cnt[k] < 2) begin
                dWEN[k]   = 1;
                daddr[k]  = ccsnoopaddr[k] + 32'(4 * sup_cnt[k]);
                dstore[k] = (sup_cnt[k] == 0) ? peer_d0 : peer_d1;
            end else if (job_act[k]) begin
                dREN[k]    = (job_kind[k] == J_READ);
                dWEN[k]    = (job_kind[k] == J_WRITE);
                cctrans[k] = job_cc[k];
                ccwrite[k] = job_ccw[k];
                daddr[k]   = job_addr[k] + 32'(4 * job_acks[k]);
                dstore[k]  = (job_acks[k] == 0) ? job_d0[k] : job_d1[k];
            end
        end
    endtask

    // RAM model and ack scoreboard, evaluated on the falling edge.
    task automatic sample_half();
        @(negedge CLK);
        if (nRST) begin
            if (ramREN || ramWEN) ram_seen = 1;
            if (ramWEN && ramstate == ACCESS) begin
                wlog.push_back({ramaddr, ramstore});
                mem[ramaddr[11:2]] = ramstore;
            end
            for (int k = 0; k < 2; k++) begin
                if (!dwait[k]) begin
                    if (sup[k] && sup_cnt[k] < 2) sup_cnt[k]++;
                    else begin
                        int idx = -1;
                        for (int i = 0; i < expq.size(); i++)
                            if (expq[i].cache == k) begin idx = i; break; end
                        if (idx < 0) begin
                            tests++; fails++;
                            $display("FAIL unexpected_ack cache%0d: dwait=0, required 1", k);
                        end else begin
                            exp_t e = expq[idx];
                            expq.delete(idx);
                            if (e.chk) check($sformatf("dload%0d", k), dload[k], e.data);
                            job_acks[k]++;
                            if (job_acks[k] >= job_len[k]) begin
                                job_act[k] = 0;
                                order.push_back(k);
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic drive_half();
        @(posedge CLK);
        #1;
        drive();
    endtask

    task automatic tick();
        sample_half();
        drive_half();
    endtask

    task automatic start_job(input int k, input kind_t kind, input logic cc, input logic ccw,
                             input logic [31:0] addr, input logic [31:0] d0, input logic [31:0] d1);
        job_act[k] = 1; job_kind[k] = kind; job_cc[k] = cc; job_ccw[k] = ccw;
        job_addr[k] = addr; job_d0[k] = d0; job_d1[k] = d1; job_acks[k] = 0;
        job_len[k] = (kind == J_UPG) ? 1 : 2;
        if (kind == J_UPG) expq.push_back('{k, 1'b0, 32'h0});
        else begin
            expq.push_back('{k, kind == J_READ, d0});
            expq.push_back('{k, kind == J_READ, d1});
        end
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while ((job_act[0] || job_act[1] || expq.size() != 0) && n < limit) begin
            tick();
            n++;
        end
        if (job_act[0] || job_act[1] || expq.size() != 0) begin
            tests++; fails++;
            $display("FAIL timeout: %0d acks pending after %0d cycles, required 0", expq.size(), limit);
            job_act[0] = 0; job_act[1] = 0; expq.delete();
        end
    endtask

    task automatic wait_ccwait(input int p, input int limit);
        int n = 0;
        while (!ccwait[p] && n < limit) begin
            tick();
            n++;
        end
        check($sformatf("ccwait%0d_raised", p), ccwait[p], 1'b1);
    endtask

    task automatic do_reset();
        nRST = 0;
        job_act[0] = 0; job_act[1] = 0; expq.delete();
        @(posedge CLK);
        #1;
        drive();
        nRST = 1;
    endtask

    task automatic check_wlog(input string name, input logic [31:0] a, input logic [31:0] d0, input logic [31:0] d1);
        check({name, "_n"}, wlog.size(), 2);
        if (wlog.size() == 2) begin
            check({name, "_w0"}, wlog[0], {a, d0});
            check({name, "_w1"}, wlog[1], {a + 32'd4, d1});
        end
    endtask

    vec_t vt[6];
    logic [1:0] seq[4];
    bit rearmed;

    initial begin
        tests = 0; fails = 0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        use_ovr = 0; ovr = FREE; snp_delay = 0; peer_dirty = 0; peer_d0 = '0; peer_d1 = '0;
        for (int k = 0; k < 2; k++) begin
            job_act[k] = 0; job_acks[k] = 0; job_len[k] = 0; snp_done[k] = 0; sup[k] = 0;
            snp_cnt[k] = 0; sup_cnt[k] = 0;
        end
        dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0; snpvalid = '0; snpdirty = '0;
        daddr = '0; dstore = '0;
        nRST = 0;
        repeat (2) @(posedge CLK);
        #1;
        drive();
        check("rst_dwait", dwait, 2'b11);
        check("rst_cc", {ccwait, ccinv}, 4'b0);
        check("rst_snpaddr", ccsnoopaddr, 64'h0);
        check("rst_ram", {ramREN, ramWEN, ramaddr, ramstore}, 66'h0);
        check("rst_dload", dload, 64'h0);
        nRST = 1;
        tick();

        vt[0] = '{0, J_READ,  32'h100, 32'h0000_AAAA, 32'h0000_BBBB, 1'b1};
        vt[1] = '{1, J_WRITE, 32'h300, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0};
        vt[2] = '{0, J_READ,  32'h300, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0};
        vt[3] = '{1, J_READ,  32'h040, 32'hCAFE_0001, 32'hCAFE_0002, 1'b1};
        vt[4] = '{0, J_WRITE, 32'h010, 32'h0BAD_F00D, 32'h0000_FFFF, 1'b0};
        vt[5] = '{1, J_READ,  32'h010, 32'h0BAD_F00D, 32'h0000_FFFF, 1'b0};
        for (int i = 0; i < 6; i++) begin
            if (vt[i].preload) begin
                mem[vt[i].addr[11:2]] = vt[i].d0;
                mem[vt[i].addr[11:2] + 10'd1] = vt[i].d1;
            end
            wlog.delete();
            start_job(vt[i].cache, vt[i].kind, 1'b0, 1'b0, vt[i].addr, vt[i].d0, vt[i].d1);
            wait_done(40);
            if (vt[i].kind == J_WRITE) check_wlog($sformatf("vec%0d_wr", i), vt[i].addr, vt[i].d0, vt[i].d1);
            check($sformatf("vec%0d_idle", i), {ramREN, ramWEN, dwait}, 4'b0011);
        end

        // Simultaneous requests after reset: cache 0 wins the first tie.
        do_reset();
        mem[32'h500 >> 2] = 32'h5; mem[(32'h500 >> 2) + 1] = 32'h6;
        mem[32'h600 >> 2] = 32'h7; mem[(32'h600 >> 2) + 1] = 32'h8;
        mem[32'h700 >> 2] = 32'h9; mem[(32'h700 >> 2) + 1] = 32'hA;
        order.delete();
        start_job(0, J_READ, 1'b0, 1'b0, 32'h500, 32'h5, 32'h6);
        start_job(1, J_READ, 1'b0, 1'b0, 32'h600, 32'h7, 32'h8);
        wait_done(60);
        check("rr_tie_after_reset", ord_code(), 32'h2001);

        // Tie again, and cache 0 re-requests right away: cache 1 must win the second tie.
        order.delete();
        start_job(0, J_READ, 1'b0, 1'b0, 32'h500, 32'h5, 32'h6);
        start_job(1, J_READ, 1'b0, 1'b0, 32'h600, 32'h7, 32'h8);
        rearmed = 0;
        for (int c = 0; c < 80; c++) begin
            sample_half();
            if (!job_act[0] && !rearmed) begin
                start_job(0, J_READ, 1'b0, 1'b0, 32'h700, 32'h9, 32'hA);
                rearmed = 1;
            end
            drive_half();
            if (rearmed && !job_act[0] && !job_act[1] && expq.size() == 0) break;
        end
        wait_done(40);
        check("rr_rerequest", ord_code(), 32'h3010);

        // Exclusive read by cache 1 hitting a dirty block in cache 0.
        mem[32'h208 >> 2] = 32'hDEAD; mem[(32'h208 >> 2) + 1] = 32'hBEEF;
        peer_dirty = 1; peer_d0 = 32'h11; peer_d1 = 32'h22; snp_delay = 2;
        wlog.delete();
        start_job(1, J_READ, 1'b1, 1'b1, 32'h208, 32'h11, 32'h22);
        wait_ccwait(0, 20);
        check("dirty_ccinv", ccinv, 2'b01);
        check("dirty_snpaddr", ccsnoopaddr[0], 32'h208);
        check("dirty_req_stall", dwait[1], 1'b1);
        wait_done(60);
        check_wlog("dirty_ramwr", 32'h208, 32'h11, 32'h22);
        check("dirty_cc_released", {ccwait, ccinv, ccsnoopaddr}, 68'h0);

        // Shared read miss by cache 0, clean peer: no invalidate, fill from RAM.
        peer_dirty = 0; snp_delay = 0;
        mem[32'h400 >> 2] = 32'h4444; mem[(32'h400 >> 2) + 1] = 32'h5555;
        start_job(0, J_READ, 1'b1, 1'b0, 32'h404, 32'h5555, 32'h0);
        job_addr[0] = 32'h400; job_d0[0] = 32'h4444; job_d1[0] = 32'h5555;
        expq.delete();
        expq.push_back('{0, 1'b1, 32'h4444});
        expq.push_back('{0, 1'b1, 32'h5555});
        wait_ccwait(1, 20);
        check("clean_ccinv", ccinv, 2'b00);
        check("clean_snpaddr", ccsnoopaddr[1], 32'h400);
        wait_done(40);

        // Upgrade by cache 1 while cache 0 (the snooped peer) has its own read pending.
        snp_delay = 1;
        mem[32'h800 >> 2] = 32'h8888; mem[(32'h800 >> 2) + 1] = 32'h9999;
        order.delete();
        start_job(1, J_UPG, 1'b1, 1'b1, 32'h208, 32'h0, 32'h0);
        ram_seen = 0;
        wait_ccwait(0, 20);
        check("upg_ccinv", ccinv[0], 1'b1);
        start_job(0, J_READ, 1'b0, 1'b0, 32'h800, 32'h8888, 32'h9999);
        for (int c = 0; c < 20 && job_act[1]; c++) tick();
        check("upg_done", job_act[1], 1'b0);
        check("upg_no_ram", ram_seen, 1'b0);
        check("upg_peer_stalled", job_acks[0], 0);
        wait_done(40);
        check("upg_then_peer", ord_code(), 32'h2010);

        // Writeback through BUSY/ERROR/BUSY/ACCESS, then reset in the middle of WB1.
        use_ovr = 1; ovr = BUSY;
        wlog.delete();
        start_job(0, J_WRITE, 1'b0, 1'b0, 32'h900, 32'h55, 32'h66);
        for (int c = 0; c < 10 && !ramWEN; c++) tick();
        check("wb_started", {ramWEN, ramaddr, ramstore}, {1'b1, 32'h900, 32'h55});
        seq[0] = BUSY; seq[1] = ERR; seq[2] = BUSY; seq[3] = ACCESS;
        for (int s = 0; s < 4; s++) begin
            ovr = seq[s];
            #2;
            check($sformatf("wb_stall_%0d", s), dwait[0], (s == 3) ? 1'b0 : 1'b1);
            tick();
        end
        ovr = BUSY;
        #1;
        check("wb1_addr", {ramWEN, ramaddr, ramstore}, {1'b1, 32'h904, 32'h66});
        nRST = 0;
        #1;
        check("midrst_dwait", dwait, 2'b11);
        check("midrst_ram", {ramREN, ramWEN, ramaddr, ramstore}, 66'h0);
        check("midrst_cc", {ccwait, ccinv, ccsnoopaddr, dload}, 132'h0);
        job_act[0] = 0; expq.delete(); use_ovr = 0;
        drive();
        #1;
        nRST = 1;
        repeat (4) tick();
        check("post_rst_idle", {ramREN, ramWEN, dwait}, 4'b0011);
        check("post_rst_wlog", {wlog.size(), (wlog.size() > 0) ? wlog[0] : 64'h0}, {32'd1, 32'h900, 32'h55});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
